// File: rtl/tpsr_fifo_pkg.sv
// Shared constants and helpers for the two-port-SRAM FIFO controller.
package tpsr_fifo_pkg;

    localparam int OBUF_DEPTH = 2;

    // Bits needed to address 'value' entries; never less than one.
    function automatic int nextpow2(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/tpsr_fifo_ctrl_obuf.sv
// Two-entry in-order output buffer that absorbs the one-cycle SRAM read latency.
module tpsr_fifo_obuf
    import tpsr_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            cnt
);

    logic [DATA_WIDTH-1:0] ent_q [OBUF_DEPTH];
    logic [DATA_WIDTH-1:0] ent_d [OBUF_DEPTH];
    logic                  wr_idx_q, wr_idx_d;
    logic                  rd_idx_q, rd_idx_d;
    logic [1:0]            cnt_q, cnt_d;

    always_comb begin
        ent_d    = ent_q;
        wr_idx_d = wr_idx_q ^ push;
        rd_idx_d = rd_idx_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) ent_d[wr_idx_q] = push_data;
        // Data is left in place on flush; only the bookkeeping is cleared.
        if (flush) begin
            wr_idx_d = 1'b0;
            rd_idx_d = 1'b0;
            cnt_d    = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ent_q    <= '{default: '0};
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ent_q    <= ent_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign head_data = ent_q[rd_idx_q];
    assign cnt       = cnt_q;

endmodule

// File: rtl/tpsr_fifo_ctrl.sv
// FIFO controller for an external two-port SRAM with a 2-entry output buffer.
// Define TPSR_FIFO_CTRL_LEVEL_EN to add the LEVEL / ALMOST_FULL outputs.
module tpsr_fifo_ctrl
    import tpsr_fifo_pkg::*;
#(
    parameter  int WORD_DEPTH = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int AF_THRESH  = 12,
    localparam int ADDR_WIDTH = nextpow2(WORD_DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  FLUSH,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [DATA_WIDTH-1:0] S_DATA,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
    output logic                  CENB,
    output logic [ADDR_WIDTH-1:0] AB,
    output logic [DATA_WIDTH-1:0] DB,
    output logic                  CENA,
    output logic [ADDR_WIDTH-1:0] AA,
    input  logic [DATA_WIDTH-1:0] QA
`ifdef TPSR_FIFO_CTRL_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] LEVEL,
    output logic                  ALMOST_FULL
`endif
);

    localparam int CNT_W = ADDR_WIDTH + 1;

    if ((WORD_DEPTH < 2) || ((WORD_DEPTH & (WORD_DEPTH - 1)) != 0) || (AF_THRESH < 1)) begin : g_bad_param
        $error("tpsr_fifo_ctrl: WORD_DEPTH must be a power of two >= 2 and AF_THRESH >= 1");
    end

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]      mem_cnt_q, mem_cnt_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  blk, wr, rd, push, pop;
    logic [2:0]            occ_after;
    logic [1:0]            obuf_cnt;
    logic [DATA_WIDTH-1:0] obuf_head;

    always_comb begin
        // Flush and reset both block every handshake and memory access this cycle.
        blk       = FLUSH || !RSTN;
        S_READY   = !blk && (mem_cnt_q != CNT_W'(WORD_DEPTH));
        wr        = S_VALID && S_READY;
        M_VALID   = !blk && (obuf_cnt != 2'd0);
        pop       = M_VALID && M_READY;
        M_DATA    = RSTN ? obuf_head : '0;
        push      = rd_pend_q && !blk;
        occ_after = {1'b0, obuf_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
        rd        = !blk && (mem_cnt_q != '0) && (occ_after < 3'd2);

        CENB = !wr;
        AB   = wptr_q;
        DB   = S_DATA;
        CENA = !rd;
        AA   = rptr_q;

        wptr_d    = wptr_q + ADDR_WIDTH'(wr);
        rptr_d    = rptr_q + ADDR_WIDTH'(rd);
        mem_cnt_d = mem_cnt_q + CNT_W'(wr) - CNT_W'(rd);
        rd_pend_d = rd;
        if (FLUSH) begin
            wptr_d    = '0;
            rptr_d    = '0;
            mem_cnt_d = '0;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    tpsr_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk       (CLK),
        .rstn      (RSTN),
        .flush     (FLUSH),
        .push      (push),
        .push_data (QA),
        .pop       (pop),
        .head_data (obuf_head),
        .cnt       (obuf_cnt)
    );

`ifdef TPSR_FIFO_CTRL_LEVEL_EN
    localparam int LVL_W = ADDR_WIDTH + 2;

    logic [LVL_W-1:0] level_q, level_d;
    logic             af_q, af_d;
    logic [1:0]       obuf_cnt_nxt;

    // Registered from next-state values so LEVEL matches the current contents.
    always_comb begin
        obuf_cnt_nxt = FLUSH ? 2'd0 : (obuf_cnt + {1'b0, push} - {1'b0, pop});
        level_d      = LVL_W'(mem_cnt_d) + LVL_W'(rd_pend_d) + LVL_W'(obuf_cnt_nxt);
        af_d         = level_d >= LVL_W'(AF_THRESH);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            level_q <= '0;
            af_q    <= 1'b0;
        end else begin
            level_q <= level_d;
            af_q    <= af_d;
        end
    end

    assign LEVEL       = level_q;
    assign ALMOST_FULL = af_q;
`endif

endmodule

// File: tb/tb_tpsr_fifo_ctrl.sv
// Self-checking bench for tpsr_fifo_ctrl: latency table, full, streaming, flush, reset and level cases.
module tb_tpsr_fifo_ctrl;

    localparam int WORD_DEPTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int AF_THRESH  = 12;
    localparam int ADDR_WIDTH = 4;

    logic                  CLK = 1'b0;
    logic                  RSTN, FLUSH, S_VALID, S_READY, M_VALID, M_READY, CENB, CENA;
    logic [DATA_WIDTH-1:0] S_DATA, M_DATA, DB, QA;
    logic [ADDR_WIDTH-1:0] AB, AA;
`ifdef TPSR_FIFO_CTRL_LEVEL_EN
    logic [ADDR_WIDTH+1:0] LEVEL;
    logic                  ALMOST_FULL;
`endif

    tpsr_fifo_ctrl #(
        .WORD_DEPTH (WORD_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .AF_THRESH  (AF_THRESH)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .FLUSH   (FLUSH),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .S_DATA  (S_DATA),
        .M_VALID (M_VALID),
        .M_READY (M_READY),
        .M_DATA  (M_DATA),
        .CENB    (CENB),
        .AB      (AB),
        .DB      (DB),
        .CENA    (CENA),
        .AA      (AA),
        .QA      (QA)
`ifdef TPSR_FIFO_CTRL_LEVEL_EN
        ,
        .LEVEL       (LEVEL),
        .ALMOST_FULL (ALMOST_FULL)
`endif
    );

    always #5 CLK = ~CLK;

    // Two-port SRAM model: write port B, read port A with one-cycle read latency.
    logic [DATA_WIDTH-1:0] mem [WORD_DEPTH];
    always @(posedge CLK) begin
        if (!CENB) mem[AB] <= DB;
        if (!CENA) QA <= mem[AA];
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rx_cnt = 0;
    int first_rx_cyc = -1;
    int last_rx_cyc  = -1;
    logic [DATA_WIDTH-1:0] sb_q [$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted writes are queued, every output handshake is checked in order.
    always @(negedge CLK) begin
        if (M_VALID && M_READY) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_unexpected: got M_DATA=%0h, required no output", M_DATA);
            end else begin
                chk("sb_data", M_DATA, sb_q.pop_front());
            end
            if (rx_cnt == 0) first_rx_cyc = cyc;
            last_rx_cyc = cyc;
            rx_cnt++;
        end
        if (S_VALID && S_READY) sb_q.push_back(S_DATA);
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int budget);
        S_VALID = 1'b0;
        M_READY = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (sb_q.size() == 0) break;
            next_cycle();
        end
        repeat (3) next_cycle();
        chk("drain_empty", sb_q.size(), 0);
    endtask

    typedef struct {
        logic                  s_valid;
        logic [DATA_WIDTH-1:0] s_data;
        logic                  m_ready;
        logic                  exp_s_ready;
        logic                  exp_cenb;
        logic [ADDR_WIDTH-1:0] exp_ab;
        logic                  exp_cena;
        logic [ADDR_WIDTH-1:0] exp_aa;
        logic                  exp_m_valid;
        logic [DATA_WIDTH-1:0] exp_m_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int sent;
        int rx_before;

        vecs[0] = '{1'b1, 32'hA5, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 32'hA5};
        vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 32'h0};

        RSTN = 1'b0; FLUSH = 1'b0; S_VALID = 1'b0; S_DATA = '0; M_READY = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("rst_s_ready", S_READY, 0);
            chk("rst_m_valid", M_VALID, 0);
            chk("rst_cena", CENA, 1);
            chk("rst_cenb", CENB, 1);
            chk("rst_m_data", M_DATA, 0);
        end
        next_cycle();
        RSTN = 1'b1;

        // Single word through an empty FIFO, row 0 is the first cycle out of reset.
        for (int i = 0; i < 5; i++) begin
            S_VALID = vecs[i].s_valid;
            S_DATA  = vecs[i].s_data;
            M_READY = vecs[i].m_ready;
            @(negedge CLK);
            chk("tbl_s_ready", S_READY, vecs[i].exp_s_ready);
            chk("tbl_cenb", CENB, vecs[i].exp_cenb);
            chk("tbl_cena", CENA, vecs[i].exp_cena);
            chk("tbl_m_valid", M_VALID, vecs[i].exp_m_valid);
            if (!vecs[i].exp_cenb) begin
                chk("tbl_ab", AB, vecs[i].exp_ab);
                chk("tbl_db", DB, vecs[i].s_data);
            end
            if (!vecs[i].exp_cena) chk("tbl_aa", AA, vecs[i].exp_aa);
            if (vecs[i].exp_m_valid) chk("tbl_m_data", M_DATA, vecs[i].exp_m_data);
            next_cycle();
        end
        S_VALID = 1'b0;

        // Fill with the reader stalled: memory plus output buffer hold 18 words.
        M_READY = 1'b0;
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            S_VALID = 1'b1;
            S_DATA  = 32'h100 + acc;
            @(negedge CLK);
            if (S_READY) acc++;
            next_cycle();
        end
        S_VALID = 1'b0;
        chk("full_accepted", acc, 18);
        @(negedge CLK);
        chk("full_s_ready", S_READY, 0);
        chk("full_m_valid", M_VALID, 1);
        chk("full_m_data", M_DATA, 32'h100);
`ifdef TPSR_FIFO_CTRL_LEVEL_EN
        chk("full_level", LEVEL, 18);
        chk("full_af", ALMOST_FULL, 1);
`endif
        next_cycle();
        drain(60);

        // Continuous streaming of 100 words, pointers wrap several times.
        M_READY = 1'b1;
        rx_cnt = 0;
        sent = 0;
        for (int i = 0; i < 400 && (sent < 100 || rx_cnt < 100); i++) begin
            S_VALID = (sent < 100);
            S_DATA  = sent;
            @(negedge CLK);
            if (S_VALID && S_READY) sent++;
            next_cycle();
        end
        S_VALID = 1'b0;
        chk("stream_rx_count", rx_cnt, 100);
        chk("stream_span", last_rx_cyc - first_rx_cyc, 99);
        chk("stream_sb_empty", sb_q.size(), 0);

        // Flush while a read is in flight with five words stored.
        M_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
            S_VALID = 1'b1;
            S_DATA  = 32'h200 + k;
            @(negedge CLK);
            chk("fl_wr_ready", S_READY, 1);
            next_cycle();
        end
        S_VALID = 1'b1; S_DATA = 32'h205; M_READY = 1'b1;
        @(negedge CLK);
        chk("fl_pop_valid", M_VALID, 1);
        chk("fl_read_issue", CENA, 0);
        next_cycle();
        FLUSH = 1'b1; S_VALID = 1'b1; S_DATA = 32'h206; M_READY = 1'b1;
        sb_q.delete();
        @(negedge CLK);
        chk("fl_s_ready", S_READY, 0);
        chk("fl_m_valid", M_VALID, 0);
        chk("fl_cena", CENA, 1);
        chk("fl_cenb", CENB, 1);
        next_cycle();
        rx_before = rx_cnt;
        FLUSH = 1'b0; S_VALID = 1'b1; S_DATA = 32'h11; M_READY = 1'b0;
        @(negedge CLK);
        chk("fl_after_m_valid", M_VALID, 0);
        chk("fl_after_s_ready", S_READY, 1);
        next_cycle();
        drain(20);
        repeat (6) next_cycle();
        chk("fl_first_only", rx_cnt - rx_before, 1);

        // Reset in the middle of a stream.
        M_READY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            S_VALID = 1'b1;
            S_DATA  = 32'h300 + k;
            next_cycle();
        end
        RSTN = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("rst2_cena", CENA, 1);
            chk("rst2_cenb", CENB, 1);
            chk("rst2_s_ready", S_READY, 0);
            chk("rst2_m_valid", M_VALID, 0);
            chk("rst2_m_data", M_DATA, 0);
            next_cycle();
        end
        RSTN = 1'b1;
        S_VALID = 1'b0;
        rx_before = rx_cnt;
        @(negedge CLK);
        chk("rst2_s_ready_after", S_READY, 1);
        chk("rst2_m_valid_after", M_VALID, 0);
        next_cycle();
        repeat (10) next_cycle();
        chk("rst2_no_stale", rx_cnt - rx_before, 0);
        S_VALID = 1'b1; S_DATA = 32'h3FF;
        next_cycle();
        drain(20);
        chk("rst2_one_out", rx_cnt - rx_before, 1);

`ifdef TPSR_FIFO_CTRL_LEVEL_EN
        // LEVEL tracks every accepted word; ALMOST_FULL rises with LEVEL reaching 12.
        M_READY = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            S_VALID = (k < 12);
            S_DATA  = 32'h400 + k;
            @(negedge CLK);
            chk("lvl_level", LEVEL, k);
            chk("lvl_af", ALMOST_FULL, (k >= AF_THRESH));
            next_cycle();
        end
        S_VALID = 1'b0;
        FLUSH = 1'b1;
        sb_q.delete();
        next_cycle();
        FLUSH = 1'b0;
        @(negedge CLK);
        chk("lvl_after_flush", LEVEL, 0);
        chk("af_after_flush", ALMOST_FULL, 0);
        next_cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
